// File: rtl/spi_cfg_scheduler.sv
// spi_cfg_scheduler: uploads a fixed boot table over SPI, then
// arbitrates ndr/host register writes outside frame-valid.
`timescale 1ns/1ps
module spi_cfg_scheduler #(
  parameter int GAP_CYC = 4,
  parameter int BOOT_N  = 16
) (
  input  logic        clock_20,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        fval,
  input  logic        ndr_req,
  input  logic [15:0] ndr_word,
  input  logic        host_req,
  input  logic [15:0] host_word,
  output logic        ndr_ack,
  output logic        host_ack,
  output logic [15:0] spi_word,
  output logic        spi_go,
  input  logic        spi_done,
  output logic        boot_done,
  output logic [1:0]  cur_src
);

  typedef enum logic [2:0] {
    IDLE,
    BOOT_ISSUE,
    BOOT_WAIT,
    GAP,
    ARB,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BOOT = 2'd1;
  localparam logic [1:0] SRC_NDR  = 2'd2;
  localparam logic [1:0] SRC_HOST = 2'd3;

  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_N - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] idx;
  logic [3:0] idx_n;
  logic [3:0] gap_cnt;
  logic       rr_host;
  logic       boot_done_n;
  logic [1:0] grant;

  function automatic logic [11:0] boot_dat(
    input logic [3:0] i
  );
    unique case (i)
      4'd0:    boot_dat = 12'h028;
      4'd1:    boot_dat = 12'h000;
      4'd2:    boot_dat = 12'h000;
      4'd3:    boot_dat = 12'h0A0;
      4'd4:    boot_dat = 12'h002;
      4'd5:    boot_dat = 12'h000;
      4'd6:    boot_dat = 12'h000;
      4'd7:    boot_dat = 12'h1E1;
      4'd8:    boot_dat = 12'h04A;
      4'd9:    boot_dat = 12'h06B;
      4'd10:   boot_dat = 12'h055;
      4'd11:   boot_dat = 12'h0F0;
      4'd12:   boot_dat = 12'hFB0;
      4'd13:   boot_dat = 12'hADF;
      4'd14:   boot_dat = 12'h6DB;
      default: boot_dat = 12'h0DB;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    boot_done_n = boot_done;
    grant       = SRC_NONE;

    // contention goes to whoever was not granted last
    unique case (1'b1)
      ndr_req && !host_req: grant = SRC_NDR;
      host_req && !ndr_req: grant = SRC_HOST;
      ndr_req && host_req:
        grant = rr_host ? SRC_HOST : SRC_NDR;
      default: grant = SRC_NONE;
    endcase

    unique case (state)
      IDLE: begin
        idx_n = '0;
        if (cfg_start) state_n = BOOT_ISSUE;
      end
      BOOT_ISSUE: state_n = BOOT_WAIT;
      BOOT_WAIT: begin
        if (spi_done) begin
          state_n = GAP;
          if (idx == BOOT_LAST)
            boot_done_n = 1'b1;
          else
            idx_n = idx + 4'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST)
          state_n = boot_done ? ARB : BOOT_ISSUE;
      end
      ARB: begin
        if (!fval && grant != SRC_NONE)
          state_n = ISSUE;
      end
      ISSUE: state_n = WAIT;
      WAIT: if (spi_done) state_n = GAP;
      default: state_n = IDLE;
    endcase

    if (!cfg_start) begin
      state_n     = IDLE;
      boot_done_n = 1'b0;
    end
  end

  always_ff @(posedge clock_20 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      spi_go    <= 1'b0;
      spi_word  <= '0;
      ndr_ack   <= 1'b0;
      host_ack  <= 1'b0;
      boot_done <= 1'b0;
      cur_src   <= SRC_NONE;
      idx       <= '0;
      gap_cnt   <= '0;
      rr_host   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      boot_done <= boot_done_n;
      spi_go    <= (state_n == BOOT_ISSUE) ||
                   (state_n == ISSUE);
      ndr_ack   <= (state == WAIT) && spi_done &&
                   cfg_start && (cur_src == SRC_NDR);
      host_ack  <= (state == WAIT) && spi_done &&
                   cfg_start && (cur_src == SRC_HOST);

      if (state == GAP && state_n == GAP) begin
        if (gap_cnt != 4'hF)
          gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= '0;
      end

      unique case (state_n)
        BOOT_ISSUE: begin
          spi_word <= {idx_n, boot_dat(idx_n)};
          cur_src  <= SRC_BOOT;
        end
        ISSUE: begin
          spi_word <= (grant == SRC_HOST) ?
                      host_word : ndr_word;
          cur_src  <= grant;
          rr_host  <= (grant == SRC_NDR);
        end
        GAP, IDLE: cur_src <= SRC_NONE;
        default: ;
      endcase
    end
  end

endmodule
